// File: rtl/alu_seq_if.sv
// Handshake, ALU drive/return, writeback report and debug read port of the
// execute-stage sequencer, bundled so the sequencer takes a single bus port.
interface alu_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        done;
  logic [3:0]  done_rd;
  logic [31:0] done_val;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  // Sequencer side
  modport slave (
    input  in_valid, in_instr, alu_res, dbg_addr,
    output in_ready, alu_op, alu_a, alu_b, done, done_rd, done_val, dbg_data
  );

  // Fetch / ALU / debug side
  modport master (
    output in_valid, in_instr, alu_res, dbg_addr,
    input  in_ready, alu_op, alu_a, alu_b, done, done_rd, done_val, dbg_data
  );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage sequencer: IDLE -> READ -> EXEC -> WB around an external ALU,
// with a 16x32 register file (r0 reads zero). Define ALU_SEQ_FAST_EN to accept in WB.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] result_q;
  logic [3:0]  alu_op_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [31:0] rf_q [16];

  logic        in_ready;
  logic        accept;
  logic [3:0]  rd, ra, rb;
  logic        immsel;
  logic [14:0] imm;
  logic [31:0] rf_a, rf_b;

  assign rd     = instr_q[27:24];
  assign ra     = instr_q[23:20];
  assign rb     = instr_q[19:16];
  assign immsel = instr_q[15];
  assign imm    = instr_q[14:0];
  assign accept = bus.in_valid & in_ready;

  function automatic logic [31:0] rf_read(input logic [3:0] addr,
                                          input logic [31:0] rows [16]);
    return (addr == 4'd0) ? 32'd0 : rows[addr];
  endfunction

  assign rf_a         = rf_read(ra, rf_q);
  assign rf_b         = rf_read(rb, rf_q);
  assign bus.dbg_data = rf_read(bus.dbg_addr, rf_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
`ifdef ALU_SEQ_FAST_EN
        state_d = accept ? S_READ : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
`ifdef ALU_SEQ_FAST_EN
    in_ready = (state_q == S_IDLE) || (state_q == S_WB);
`else
    in_ready = (state_q == S_IDLE);
`endif
    bus.done     = (state_q == S_WB);
    bus.done_rd  = (state_q == S_WB) ? rd : 4'd0;
    bus.done_val = (state_q == S_WB) ? result_q : 32'd0;
  end

  assign bus.in_ready = in_ready;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;

  // In fast mode a WB acceptance overwrites instr_q at the same edge that
  // retires the old rd, which is safe because the write uses the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= 32'd0;
      alu_op_q <= 4'd0;
      alu_a_q  <= 32'd0;
      alu_b_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      if (accept) begin
        instr_q <= bus.in_instr;
      end
      if (state_q == S_READ) begin
        alu_op_q <= instr_q[31:28];
        alu_a_q  <= rf_a;
        alu_b_q  <= immsel ? {17'd0, imm} : rf_b;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus.alu_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if ((state_q == S_WB) && (rd != 4'd0)) begin
      rf_q[rd] <= result_q;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU on the result path.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef ALU_SEQ_FAST_EN
  localparam int PERIOD = 3;
`else
  localparam int PERIOD = 4;
`endif

  alu_seq_if bus();

  alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b - a;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd10:   return b;
      4'd11:   return {b[15:0], a[15:0]};
      default: return a;
    endcase
  endfunction

  assign bus.alu_res = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic immsel, input logic [14:0] imm);
    return {op, rd, ra, rb, immsel, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers instr until accepted; returns cycles spent waiting for in_ready.
  task automatic issue(input logic [31:0] instr, output int waited);
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 16) begin
      step();
      waited++;
    end
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_instr = 32'hFFFF_FFFF;
  endtask

  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic [31:0] exp_val);
    int w;
    logic [3:0] rd;
    rd = instr[27:24];
    issue(instr, w);
    step();
    check({tag, "_op"}, {28'd0, bus.alu_op}, {28'd0, instr[31:28]});
    check({tag, "_a"}, bus.alu_a, exp_a);
    check({tag, "_b"}, bus.alu_b, exp_b);
    check({tag, "_early_done"}, {31'd0, bus.done}, 32'd0);
    step();
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_done_rd"}, {28'd0, bus.done_rd}, {28'd0, rd});
    check({tag, "_done_val"}, bus.done_val, exp_val);
    step();
    check({tag, "_done_clear"}, {31'd0, bus.done}, 32'd0);
    $display("instr %-10s %h -> rd=%0d val=%h", tag, instr, rd, exp_val);
  endtask

  task automatic rf_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
    $display("dbg   r%0d = %h", addr, bus.dbg_data);
  endtask

  initial begin
    int w;
    int pulses;
    int nq;
    int n_exp;
    logic [31:0] vals [$];

    bus.in_valid = 1'b0;
    bus.in_instr = 32'd0;
    bus.dbg_addr = 4'd0;

    // Power-on reset
    step();
    step();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_done_val", bus.done_val, 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-EXEC of a write to r3
    issue(mk(4'd10, 4'd3, 4'd0, 4'd0, 1'b1, 15'h0077), w);
    step();
    check("pre_rst_b", bus.alu_b, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_op", {28'd0, bus.alu_op}, 32'd0);
    check("mid_rst_a", bus.alu_a, 32'd0);
    check("mid_rst_b", bus.alu_b, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) pulses++;
      step();
    end
    check("rst_no_done", pulses, 32'd0);
    check("rst_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("rst_b_after", bus.alu_b, 32'd0);
    rf_check("rst_r3", 4'd3, 32'd0);
    $display("reset abort: done pulses=%0d", pulses);

    // Immediates and load-high
    run_instr("ldi_r1", mk(4'd10, 4'd1, 4'd0, 4'd0, 1'b1, 15'h1234), 32'd0, 32'h1234, 32'h0000_1234);
    rf_check("r1_low", 4'd1, 32'h0000_1234);
    run_instr("ldhi_r1", mk(4'd11, 4'd1, 4'd1, 4'd0, 1'b1, 15'h00AB), 32'h1234, 32'hAB, 32'h00AB_1234);
    rf_check("r1_high", 4'd1, 32'h00AB_1234);

    // Immediate zero-extension with rb field non-zero
    run_instr("ldi_r8", mk(4'd10, 4'd8, 4'd1, 4'd1, 1'b1, 15'h7FFF), 32'h00AB_1234, 32'h7FFF, 32'h0000_7FFF);

    // Register-register subtract
    run_instr("ldi_r2", mk(4'd10, 4'd2, 4'd0, 4'd0, 1'b1, 15'd5), 32'd0, 32'd5, 32'd5);
    run_instr("ldi_r3", mk(4'd10, 4'd3, 4'd0, 4'd0, 1'b1, 15'd7), 32'd0, 32'd7, 32'd7);
    run_instr("rsub_r4", mk(4'd2, 4'd4, 4'd2, 4'd3, 1'b0, 15'd0), 32'd5, 32'd7, 32'd2);
    rf_check("r4_rsub", 4'd4, 32'd2);
    run_instr("sub_r4", mk(4'd1, 4'd4, 4'd2, 4'd3, 1'b0, 15'd0), 32'd5, 32'd7, 32'hFFFF_FFFE);
    rf_check("r4_sub", 4'd4, 32'hFFFF_FFFE);

    // r0 discard
    run_instr("ldi_r0", mk(4'd10, 4'd0, 4'd0, 4'd0, 1'b1, 15'h55), 32'd0, 32'h55, 32'h55);
    rf_check("r0_zero", 4'd0, 32'd0);
    run_instr("add_r7", mk(4'd0, 4'd7, 4'd0, 4'd0, 1'b1, 15'd3), 32'd0, 32'd3, 32'd3);

    // Handshake hold-off: valid held, instr changes every cycle
    bus.in_valid = 1'b1;
    bus.in_instr = mk(4'd10, 4'd6, 4'd0, 4'd0, 1'b1, 15'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      bus.in_instr = mk(4'd10, 4'd6, 4'd0, 4'd0, 1'b1, 15'(k + 1));
      if (bus.done) vals.push_back(bus.done_val);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.done) vals.push_back(bus.done_val);
    end
    nq = vals.size();
    n_exp = (12 + PERIOD - 1) / PERIOD;
    check("holdoff_count", nq, n_exp);
    for (int i = 0; i < n_exp && i < nq; i++) begin
      check("holdoff_val", vals[i], 32'(i * PERIOD));
      $display("holdoff accept %0d val=%h", i, vals[i]);
    end
    rf_check("r6_holdoff", 4'd6, 32'((n_exp - 1) * PERIOD));

    // Back-to-back dependency through r5
    issue(mk(4'd0, 4'd5, 4'd0, 4'd0, 1'b1, 15'd9), w);
    issue(mk(4'd0, 4'd5, 4'd5, 4'd0, 1'b1, 15'd1), w);
    check("b2b_wait", w, PERIOD - 1);
    step();
    check("b2b_a", bus.alu_a, 32'd9);
    step();
    check("b2b_done", {31'd0, bus.done}, 32'd1);
    check("b2b_val", bus.done_val, 32'd10);
    step();
    rf_check("r5_b2b", 4'd5, 32'd10);
    $display("b2b: second accept after %0d wait cycles", w);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Execute-stage sequencer that drives the combinational ALU. It accepts one 32-bit instruction per handshake and decodes it into the ALU opcode and operands. It reads operands from an internal 16×32 register file, presents them to the ALU, captures the ALU result and writes it back. It sits between instruction fetch and the ALU, and is the only driver of the ALU `op`/`a`/`b` inputs.

## Interface
Parameters:
- None. Widths are fixed: 32-bit data, 4-bit ALU opcode, 16 registers.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  block can accept an instruction.
- `in_instr`  in  32  instruction fields:
  - [31:28] ALU op
  - [27:24] rd
  - [23:20] ra
  - [19:16] rb
  - [15] immsel
  - [14:0] imm
- `alu_op`  out  4  opcode to the ALU; registered.
- `alu_a`  out  32  operand a to the ALU; registered.
- `alu_b`  out  32  operand b to the ALU; registered.
- `alu_res`  in  32  combinational ALU result.
- `done`  out  1  one-cycle pulse: writeback in progress.
- `done_rd`  out  4  destination register of the completing instruction.
- `done_val`  out  32  value being written back.
- `dbg_addr`  in  4  debug register-file read address.
- `dbg_data`  out  32  combinational read of `rf[dbg_addr]`; `r0` reads 0.

## Operation
- State machine: IDLE → READ → EXEC → WB → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_instr` and go to READ.
  - With no `in_valid`, stay in IDLE.
- READ:
  - At exit, load `alu_op`=instr[31:28] and `alu_a`=rf[ra].
  - Also load `alu_b` = immsel ? {17'b0, imm} : rf[rb].
  - Go to EXEC.
- EXEC:
  - Operands are stable and the ALU settles.
  - At exit, capture `alu_res` into the result register and go to WB.
- WB:
  - `done`=1, `done_rd`=rd, `done_val`=result.
  - At exit, write rf[rd]=result; if rd=0 the write is discarded.
  - Go to IDLE.
- Register `r0` is hardwired zero on both the read ports and `dbg_data`.
- All 16 ALU opcodes are passed through unmodified; the sequencer does not interpret them.
- `alu_op`/`alu_a`/`alu_b` hold their last values until the next READ exit.
- `in_instr` is ignored whenever `in_ready`=0.

## Timing
- Accept edge E0 (IDLE→READ).
- E1: operands registered.
- E2: result captured.
- `done` high for exactly the cycle between E2 and E3.
- E3: register file written, state returns to IDLE.
- Base throughput: one instruction per 4 cycles.
- Back-to-back dependency (rd of instruction N = ra of N+1): N+1's READ occurs after N's E3 write, so it sees the new value. No hazard logic is needed.
- Reset (asynchronous, any state):
  - state=IDLE
  - `in_ready`=1 once `rst_n` deasserts
  - `done`=0, `done_rd`=0, `done_val`=0
  - `alu_op`=0, `alu_a`=0, `alu_b`=0
  - result register=0
  - all registers=0
- Reset mid-instruction aborts it: no writeback and no `done`.

## Configuration
- `ALU_SEQ_FAST_EN`, when defined:
  - `in_ready`=1 in both IDLE and WB.
  - Acceptance in WB goes directly WB→READ; the WB write still occurs at that same edge.
  - Throughput is one instruction per 3 cycles.
  - The following READ still sees the just-written value.
- Undefined: `in_ready` is high only in IDLE, giving a 4-cycle period.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-EXEC of a write to r3 → after release:
  - `done` never pulses
  - `dbg_data`(r3)=0
  - `in_ready`=1
  - `alu_op`/`alu_a`/`alu_b`=0
- **Immediates and load-high:**
  - Issue op 1010, rd=1, immsel=1, imm=0x1234 → `done` 3 cycles after accept, `done_val`=0x00001234, r1=0x00001234.
  - Then issue op 1011, rd=1, ra=1, immsel=1, imm=0x00AB → r1=0x00AB1234.
- **Register-register subtract:**
  - Set r2=5 and r3=7.
  - Issue op 0010 (b−a), rd=4, ra=2, rb=3 → r4=2.
  - Issue op 0001 (a−b) → r4=0xFFFFFFFE.
- **r0 discard:** write 0x55 to rd=0 → `done` pulses with `done_rd`=0 and `done_val`=0x55, but `dbg_data`(r0)=0. A later read of ra=0 gives `alu_a`=0.
- **Handshake hold-off:** hold `in_valid`=1 continuously with changing `in_instr` → exactly one instruction accepted per 4 cycles (3 cycles with `ALU_SEQ_FAST_EN`). Instructions presented while `in_ready`=0 are never executed.
- **Back-to-back dependency:** op 0000 r5=r0+imm 9, then op 0000 r5=r5+imm 1 issued at the first legal accept → r5=10 in both configurations.
